// File: rtl/ticket_pkg.sv
// Shared types and constants for the booth-side ticket issuer and the gate-side counter.
package ticket_pkg;

  localparam int unsigned TICKET_W      = 5;
  localparam int unsigned COUNT_W       = 8;
  localparam int unsigned HOME_MIN_ONES = 3;

  localparam logic SIDE_HOME = 1'b0;
  localparam logic SIDE_AWAY = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    PRESENT
  } state_t;

endpackage

// File: rtl/ticket_class.sv
// Classifies a ticket code by popcount: enough ones makes it a home ticket.
module ticket_class
  import ticket_pkg::*;
(
  input  logic [TICKET_W-1:0] code,
  output logic                home
);

  logic [3:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < int'(TICKET_W); i++) begin
      ones = ones + {3'd0, code[i]};
    end
    home = (ones >= 4'(HOME_MIN_ONES));
  end

endmodule

// File: rtl/ticket_issuer.sv
// Ticket vending FSM: scans per-side cursors for the next unused code of the requested class.
// Optional ack timeout in PRESENT is enabled by defining TICKET_TIMEOUT_EN.
module ticket_issuer
  import ticket_pkg::*;
#(
  parameter int unsigned CAP     = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req,
  input  logic                side,
  input  logic                ack,
  output logic [TICKET_W-1:0] ticketID,
  output logic                valid,
  output logic                busy,
  output logic [COUNT_W-1:0]  numSoldH,
  output logic [COUNT_W-1:0]  numSoldA,
  output logic                soldOutErr,
  output logic                timeoutErr
);

  state_t              state_q, state_d;
  logic [TICKET_W-1:0] cur_h_q, cur_h_d;
  logic [TICKET_W-1:0] cur_a_q, cur_a_d;
  logic [TICKET_W-1:0] ticket_q, ticket_d;
  logic [COUNT_W-1:0]  num_h_q, num_h_d;
  logic [COUNT_W-1:0]  num_a_q, num_a_d;
  logic                side_q, side_d;
  logic                so_err_q, so_err_d;

  logic [TICKET_W-1:0] cand;
  logic                cand_home;
  logic                match;
  logic [COUNT_W-1:0]  req_sold;

  assign cand  = (side_q == SIDE_AWAY) ? cur_a_q : cur_h_q;
  assign match = (cand_home == (side_q == SIDE_HOME));
  assign req_sold = (side == SIDE_AWAY) ? num_a_q : num_h_q;

  ticket_class u_class (
    .code (cand),
    .home (cand_home)
  );

`ifdef TICKET_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_err_q, tmo_err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_comb begin
    state_d  = state_q;
    cur_h_d  = cur_h_q;
    cur_a_d  = cur_a_q;
    ticket_d = ticket_q;
    num_h_d  = num_h_q;
    num_a_d  = num_a_q;
    side_d   = side_q;
    so_err_d = 1'b0;
`ifdef TICKET_TIMEOUT_EN
    tmo_d     = tmo_q;
    tmo_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          side_d = side;
          if (req_sold == COUNT_W'(CAP)) begin
            so_err_d = 1'b1;
          end else begin
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        // The candidate is consumed whether or not it matches.
        if (side_q == SIDE_AWAY) begin
          cur_a_d = cand + 5'd1;
        end else begin
          cur_h_d = cand + 5'd1;
        end
        if (match) begin
          ticket_d = cand;
          state_d  = PRESENT;
`ifdef TICKET_TIMEOUT_EN
          tmo_d = '0;
`endif
        end
      end
      PRESENT: begin
        if (ack) begin
          if (side_q == SIDE_AWAY) begin
            num_a_d = num_a_q + 8'd1;
          end else begin
            num_h_d = num_h_q + 8'd1;
          end
          state_d = IDLE;
        end
`ifdef TICKET_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          tmo_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      cur_h_q  <= '0;
      cur_a_q  <= '0;
      ticket_q <= '0;
      num_h_q  <= '0;
      num_a_q  <= '0;
      side_q   <= SIDE_HOME;
      so_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_h_q  <= cur_h_d;
      cur_a_q  <= cur_a_d;
      ticket_q <= ticket_d;
      num_h_q  <= num_h_d;
      num_a_q  <= num_a_d;
      side_q   <= side_d;
      so_err_q <= so_err_d;
    end
  end

`ifdef TICKET_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign timeoutErr = tmo_err_q;
`else
  assign timeoutErr = 1'b0;
`endif

  assign ticketID   = ticket_q;
  assign valid      = (state_q == PRESENT);
  assign busy       = (state_q == SEARCH) || (state_q == PRESENT);
  assign numSoldH   = num_h_q;
  assign numSoldA   = num_a_q;
  assign soldOutErr = so_err_q;

endmodule

// File: tb/tb_ticket_issuer.sv
// Directed self-checking bench for ticket_issuer: vector table plus hand-written corner sequences.
module tb_ticket_issuer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       req = 1'b0;
  logic       side = 1'b0;
  logic       ack = 1'b0;
  logic [4:0] ticketID;
  logic       valid;
  logic       busy;
  logic [7:0] numSoldH;
  logic [7:0] numSoldA;
  logic       soldOutErr;
  logic       timeoutErr;

  int checks = 0;
  int errors = 0;

  ticket_issuer #(
    .CAP     (16),
    .TIMEOUT (15)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req        (req),
    .side       (side),
    .ack        (ack),
    .ticketID   (ticketID),
    .valid      (valid),
    .busy       (busy),
    .numSoldH   (numSoldH),
    .numSoldA   (numSoldA),
    .soldOutErr (soldOutErr),
    .timeoutErr (timeoutErr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       side;
    logic [4:0] id;
    logic [7:0] h;
    logic [7:0] a;
  } vec_t;

  vec_t vecs[18];
  int   home_seq[16] = '{7, 11, 13, 14, 15, 19, 21, 22, 23, 25, 26, 27, 28, 29, 30, 31};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req = 1'b0;
    ack = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Issues a one-cycle request, then waits for valid; n = cycles after SEARCH entry.
  task automatic request(input logic s, output int n);
    req  = 1'b1;
    side = s;
    tick();
    req = 1'b0;
    n = 0;
    while (!valid && n < 40) begin
      tick();
      n++;
    end
    if (!valid) chk("valid_timeout_bound", 0, 1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    int n;
    logic [4:0] held;

    vecs[0] = '{1'b1, 5'd0, 8'd0, 8'd1};
    vecs[1] = '{1'b0, 5'd7, 8'd1, 8'd1};
    vecs[2] = '{1'b1, 5'd1, 8'd1, 8'd2};
    for (int i = 1; i < 16; i++) begin
      vecs[2 + i] = '{1'b0, 5'(home_seq[i]), 8'(i + 1), 8'd2};
    end

    // Reset state
    do_reset();
    chk("reset_valid", int'(valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_id", int'(ticketID), 0);
    chk("reset_numH", int'(numSoldH), 0);
    chk("reset_numA", int'(numSoldA), 0);
    chk("reset_soerr", int'(soldOutErr), 0);
    chk("reset_tmoerr", int'(timeoutErr), 0);

    // First home ticket with ack held high: valid exactly at t+9
    ack = 1'b1;
    request(1'b0, n);
    chk("first_latency", n, 8);
    chk("first_id", int'(ticketID), 7);
    tick();
    ack = 1'b0;
    chk("first_valid_drop", int'(valid), 0);
    chk("first_numH", int'(numSoldH), 1);
    chk("first_numA", int'(numSoldA), 0);

    // Interleaved away/home/away, then all remaining home codes
    do_reset();
    for (int i = 0; i < 18; i++) begin
      request(vecs[i].side, n);
      chk($sformatf("vec%0d_id", i), int'(ticketID), int'(vecs[i].id));
      chk($sformatf("vec%0d_busy", i), int'(busy), 1);
      do_ack();
      chk($sformatf("vec%0d_valid", i), int'(valid), 0);
      chk($sformatf("vec%0d_numH", i), int'(numSoldH), int'(vecs[i].h));
      chk($sformatf("vec%0d_numA", i), int'(numSoldA), int'(vecs[i].a));
    end

    // 17th home request is refused
    req  = 1'b1;
    side = 1'b0;
    tick();
    req = 1'b0;
    chk("soldout_pulse", int'(soldOutErr), 1);
    chk("soldout_valid", int'(valid), 0);
    chk("soldout_busy", int'(busy), 0);
    tick();
    chk("soldout_pulse_end", int'(soldOutErr), 0);
    chk("soldout_still_idle", int'(busy), 0);
    chk("soldout_numH", int'(numSoldH), 16);

    // Ack withheld, with a stray request during PRESENT
    do_reset();
    request(1'b0, n);
    held = ticketID;
    chk("hold_id", int'(held), 7);
    req  = 1'b1;
    side = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("hold%0d_valid", i), int'(valid), 1);
      chk($sformatf("hold%0d_id", i), int'(ticketID), int'(held));
    end
    req = 1'b0;
    chk("hold_numH_pre", int'(numSoldH), 0);
    do_ack();
    chk("hold_numH", int'(numSoldH), 1);
    chk("hold_numA", int'(numSoldA), 0);
    tick();
    chk("hold_no_stray_req", int'(busy), 0);
    chk("hold_numH_once", int'(numSoldH), 1);

    // RST while presenting
    request(1'b0, n);
    chk("rst_pre_id", int'(ticketID), 11);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_numH", int'(numSoldH), 0);
    chk("rst_numA", int'(numSoldA), 0);
    request(1'b0, n);
    chk("rst_next_id", int'(ticketID), 7);
    do_ack();

`ifdef TICKET_TIMEOUT_EN
    // Abandoned ticket: 15 PRESENT cycles then timeout
    do_reset();
    request(1'b0, n);
    chk("tmo_id", int'(ticketID), 7);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk($sformatf("tmo_valid%0d", i), int'(valid), 1);
    end
    tick();
    chk("tmo_valid_drop", int'(valid), 0);
    chk("tmo_pulse", int'(timeoutErr), 1);
    chk("tmo_numH", int'(numSoldH), 0);
    tick();
    chk("tmo_pulse_end", int'(timeoutErr), 0);
    request(1'b0, n);
    chk("tmo_next_id", int'(ticketID), 11);
    do_ack();
`else
    // Without the timeout, PRESENT waits indefinitely
    do_reset();
    request(1'b1, n);
    chk("wait_id", int'(ticketID), 0);
    for (int i = 0; i < 20; i++) tick();
    chk("wait_valid", int'(valid), 1);
    chk("wait_tmoerr", int'(timeoutErr), 0);
    do_ack();
    chk("wait_numA", int'(numSoldA), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
